rtlola_input_queue: RTL and testbench
=====================================

# rtlola_input_queue

Event input queue placed directly upstream of the generated RTLola monitor (`topEntity`). Producers push input events (x1/x2/x3 values plus per-stream presence flags); the queue timestamps each event with a free-running cycle count and holds it. The monitor pulls events one at a time with a valid/ready handshake, so bursts arriving faster than the monitor's evaluation rate are not lost. Presence flags map one-to-one onto the monitor's `hasX1..hasX3` inputs.

## Interface
- `DATA_W`, 32: width of each signed stream value.
- `DEPTH`, 4: queue entries; must be a power of two and at least 2.
- `TS_W`, 32: timestamp and cycle-counter width.

- `clk`  in  1  system clock (100 MHz domain of the monitor).
- `rst`  in  1  reset, asynchronous, active-low.
- `push_valid`  in  1  producer offers an event.
- `push_ready`  out  1  queue can accept; equals `!full`.
- `x1`, `x2`, `x3`  in  DATA_W each  signed event values.
- `has_x1`, `has_x2`, `has_x3`  in  1 each  stream-present flags.
- `out_valid`  out  1  head entry available.
- `out_ready`  in  1  monitor consumes the head this cycle.
- `out_x1`, `out_x2`, `out_x3`  out  DATA_W each  head values.
- `out_has_x1`, `out_has_x2`, `out_has_x3`  out  1 each  head flags.
- `out_ts`  out  TS_W  head timestamp.
- `level`  out  $clog2(DEPTH)+1  current entry count.
- `overflow`  out  1  sticky; set when an event is dropped because the queue is full.
- `clr_overflow`  in  1  clears `overflow`.

## Operation
- Cycle counter `now`: reset value 0; increments every cycle; wraps from 2^TS_W-1 to 0.
- Push accepted when `push_valid && push_ready && (has_x1|has_x2|has_x3)`. The stored entry is {x1..x3, has flags, ts=`now` of the accept cycle}.
- Push with all has flags 0 is discarded silently. It sets no flags and does not change `level`.
- Push while full (`push_valid && !push_ready`, at least one has flag set): event dropped; `overflow` set next cycle.
- Pop when `out_valid && out_ready`; the read pointer advances.
- Storage is a circular buffer. Write and read pointers are $clog2(DEPTH)+1 bits, with the extra bit distinguishing full from empty. Pointers wrap at DEPTH.
- Simultaneous push and pop in the same cycle:
  - Non-empty, non-full queue: both take effect; `level` is unchanged.
  - Full queue: the pop proceeds and the push is refused, because `push_ready` was 0. `overflow` is set.
  - Empty queue: only the push takes effect; there is no bypass.
- When `out_valid`=0, all `out_x*`, `out_has_*` and `out_ts` are driven 0.
- `clr_overflow` coinciding with a new drop: the set wins, so `overflow` stays 1.
- Reset (asynchronous, any time):
  - Pointers and `level` go to 0; `now` goes to 0; `overflow` goes to 0.
  - `out_valid`=0, `push_ready`=1, all `out_*`=0.
  - Queued entries are lost. Storage contents need not be cleared.

## Timing
- Push to `out_valid` latency is 1 cycle. An event accepted at edge N is visible on the outputs after edge N, with `out_ts`=N.
- Pop takes effect at the clock edge. The next entry, or `out_valid`=0, appears immediately after that edge, so back-to-back pops sustain one event per cycle.
- `push_ready`, `level` and `overflow` are registered-state outputs. None of them depend combinationally on `out_ready` or `push_valid`.
- `out_*` are combinational from storage indexed by the read pointer. There are no combinational paths from `push_*` to `out_*`.

## Configuration
- `RTLOLA_QUEUE_TIMESTAMP_EN` defined:
  - The `now` counter and per-entry TS_W timestamp storage are compiled in.
  - `out_ts` carries the capture cycle.
- Not defined:
  - The counter and timestamp storage are removed.
  - `out_ts` is tied to 0.
  - All other behaviour is identical.

## Test plan
- Reset, then push {x1=1, x2=2, has=110} at cycle 10 with `out_ready`=0 -> next cycle `out_valid`=1, `out_x1`=1, `out_x2`=2, `out_has`=110, `out_ts`=10, `level`=1.
- Push 4 events (x1=1..4) with `out_ready`=0 -> `push_ready`=0 and `level`=4. A 5th push -> `overflow`=1 and `level` stays 4. Then drain with `out_ready`=1 -> outputs 1,2,3,4 on consecutive cycles, then `out_valid`=0.
- With 2 entries queued, push and pop in the same cycle repeatedly for 10 cycles -> `level` stays 2 and data stays in order. Pointers wrap past DEPTH with no corruption.
- Push with has=000 and x1=7 -> `level` unchanged, `out_valid` stays 0, `overflow` stays 0.
- Full queue plus push and pop in the same cycle -> one entry leaves, the push is refused, `overflow`=1, `level`=3. Assert `clr_overflow` -> `overflow`=0.
- Assert `rst`=0 mid-drain with 3 entries queued -> outputs zero immediately, `push_ready`=1, `level`=0. After release, the first push gets an `out_ts` counted from 0.

Source files
------------

// File: rtl/rtlola_input_queue.sv
// rtlola_input_queue
//
// Event queue in front of the RTLola monitor. Producers push events (three signed stream
// values plus presence flags); each accepted event is stored in a circular buffer and
// optionally timestamped with a free-running cycle count. The monitor pops one event per
// valid/ready handshake.
//
// Optional feature macro: RTLOLA_QUEUE_TIMESTAMP_EN
//   defined   : cycle counter and per-entry timestamps are built; out_ts = capture cycle
//   undefined : no counter or timestamp storage; out_ts tied to 0
//
// Ports
//   clk, rst                 clock, asynchronous active-low reset
//   push_valid / push_ready  producer handshake (push_ready = !full)
//   x1..x3, has_x1..has_x3   event values and stream-present flags
//   out_valid / out_ready    consumer handshake on the head entry
//   out_x1..x3, out_has_x*   head entry (zero when out_valid = 0)
//   out_ts                   head timestamp
//   level                    current entry count
//   overflow, clr_overflow   sticky drop flag and its clear
module rtlola_input_queue #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned TS_W   = 32
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        push_valid,
  output logic                        push_ready,
  input  logic signed [DATA_W-1:0]    x1,
  input  logic signed [DATA_W-1:0]    x2,
  input  logic signed [DATA_W-1:0]    x3,
  input  logic                        has_x1,
  input  logic                        has_x2,
  input  logic                        has_x3,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic signed [DATA_W-1:0]    out_x1,
  output logic signed [DATA_W-1:0]    out_x2,
  output logic signed [DATA_W-1:0]    out_x3,
  output logic                        out_has_x1,
  output logic                        out_has_x2,
  output logic                        out_has_x3,
  output logic [TS_W-1:0]             out_ts,
  output logic [$clog2(DEPTH):0]      level,
  output logic                        overflow,
  input  logic                        clr_overflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic          overflow_q, overflow_d;

  logic signed [DATA_W-1:0] x1_mem_q [DEPTH];
  logic signed [DATA_W-1:0] x2_mem_q [DEPTH];
  logic signed [DATA_W-1:0] x3_mem_q [DEPTH];
  logic [2:0]               has_mem_q [DEPTH];

  logic          empty, full, any_has;
  logic          push_acc, pop, drop;
  logic [AW-1:0] waddr, raddr;

  assign waddr   = wptr_q[AW-1:0];
  assign raddr   = rptr_q[AW-1:0];
  assign empty   = (wptr_q == rptr_q);
  assign full    = (wptr_q[AW] != rptr_q[AW]) && (waddr == raddr);
  assign any_has = has_x1 | has_x2 | has_x3;

  // Events with no stream present are discarded without touching any state.
  assign push_acc = push_valid && !full && any_has;
  assign drop     = push_valid && full && any_has;
  assign pop      = !empty && out_ready;

  assign push_ready = !full;
  assign out_valid  = !empty;
  assign level      = wptr_q - rptr_q;
  assign overflow   = overflow_q;

  always_comb begin
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    overflow_d = overflow_q;
    if (push_acc) begin
      wptr_d = wptr_q + PW'(1);
    end
    if (pop) begin
      rptr_d = rptr_q + PW'(1);
    end
    // A new drop wins over a simultaneous clear.
    if (drop) begin
      overflow_d = 1'b1;
    end else if (clr_overflow) begin
      overflow_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      overflow_q <= overflow_d;
    end
  end

  // Storage needs no reset; the pointers decide what is valid.
  always_ff @(posedge clk) begin
    if (push_acc) begin
      x1_mem_q[waddr]  <= x1;
      x2_mem_q[waddr]  <= x2;
      x3_mem_q[waddr]  <= x3;
      has_mem_q[waddr] <= {has_x1, has_x2, has_x3};
    end
  end

  always_comb begin
    out_x1     = '0;
    out_x2     = '0;
    out_x3     = '0;
    out_has_x1 = 1'b0;
    out_has_x2 = 1'b0;
    out_has_x3 = 1'b0;
    if (out_valid) begin
      out_x1     = x1_mem_q[raddr];
      out_x2     = x2_mem_q[raddr];
      out_x3     = x3_mem_q[raddr];
      out_has_x1 = has_mem_q[raddr][2];
      out_has_x2 = has_mem_q[raddr][1];
      out_has_x3 = has_mem_q[raddr][0];
    end
  end

`ifdef RTLOLA_QUEUE_TIMESTAMP_EN
  logic [TS_W-1:0] now_q, now_d;
  logic [TS_W-1:0] ts_mem_q [DEPTH];

  always_comb begin
    now_d = now_q + TS_W'(1);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      now_q <= '0;
    end else begin
      now_q <= now_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_acc) begin
      ts_mem_q[waddr] <= now_q;
    end
  end

  assign out_ts = out_valid ? ts_mem_q[raddr] : '0;
`else
  assign out_ts = '0;
`endif

endmodule

// File: tb/tb_rtlola_input_queue.sv
// Self-checking bench for rtlola_input_queue: directed scenarios with literal expectations
// plus a randomized phase, all checked every cycle against a queue-based reference model.
module tb_rtlola_input_queue;

  localparam int unsigned DATA_W = 32;
  localparam int unsigned DEPTH  = 4;
  localparam int unsigned TS_W   = 32;
`ifdef RTLOLA_QUEUE_TIMESTAMP_EN
  localparam bit TsEn = 1'b1;
`else
  localparam bit TsEn = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              push_valid = 1'b0;
  logic              push_ready;
  logic [DATA_W-1:0] x1 = '0, x2 = '0, x3 = '0;
  logic              has_x1 = 1'b0, has_x2 = 1'b0, has_x3 = 1'b0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [DATA_W-1:0] out_x1, out_x2, out_x3;
  logic              out_has_x1, out_has_x2, out_has_x3;
  logic [TS_W-1:0]   out_ts;
  logic [$clog2(DEPTH):0] level;
  logic              overflow;
  logic              clr_overflow = 1'b0;

  rtlola_input_queue #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .TS_W   (TS_W)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .push_valid   (push_valid),
    .push_ready   (push_ready),
    .x1           (x1),
    .x2           (x2),
    .x3           (x3),
    .has_x1       (has_x1),
    .has_x2       (has_x2),
    .has_x3       (has_x3),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_x1       (out_x1),
    .out_x2       (out_x2),
    .out_x3       (out_x3),
    .out_has_x1   (out_has_x1),
    .out_has_x2   (out_has_x2),
    .out_has_x3   (out_has_x3),
    .out_ts       (out_ts),
    .level        (level),
    .overflow     (overflow),
    .clr_overflow (clr_overflow)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [DATA_W-1:0] x1;
    logic [DATA_W-1:0] x2;
    logic [DATA_W-1:0] x3;
    logic [2:0]        has;
    logic [TS_W-1:0]   ts;
  } ent_t;

  ent_t            mq[$];
  logic [TS_W-1:0] now_m = '0;
  bit              ovf_m = 1'b0;

  initial begin
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
        mq.delete();
        now_m = '0;
        ovf_m = 1'b0;
      end else begin
        bit   any, is_full, do_pop;
        ent_t e;
        any     = has_x1 || has_x2 || has_x3;
        is_full = (mq.size() == DEPTH);
        do_pop  = (mq.size() > 0) && out_ready;
        if (do_pop) void'(mq.pop_front());
        if (push_valid && any && !is_full) begin
          e.x1 = x1; e.x2 = x2; e.x3 = x3;
          e.has = {has_x1, has_x2, has_x3};
          e.ts = now_m;
          mq.push_back(e);
        end
        if (push_valid && any && is_full) ovf_m = 1'b1;
        else if (clr_overflow) ovf_m = 1'b0;
        now_m = now_m + 1;
      end
    end
  end

  // Compare process: outputs depend only on registered state, so checking on the falling
  // edge sees a settled value.
  initial begin
    forever begin
      @(negedge clk);
      begin
        ent_t h;
        bit   v;
        v = (mq.size() > 0);
        h = v ? mq[0] : '0;
        chk("m_out_valid",  64'(out_valid), 64'(v));
        chk("m_push_ready", 64'(push_ready), 64'(mq.size() < DEPTH));
        chk("m_level",      64'(level), 64'(mq.size()));
        chk("m_overflow",   64'(overflow), 64'(ovf_m));
        chk("m_out_x1",     64'(out_x1), 64'(h.x1));
        chk("m_out_x2",     64'(out_x2), 64'(h.x2));
        chk("m_out_x3",     64'(out_x3), 64'(h.x3));
        chk("m_out_has",    64'({out_has_x1, out_has_x2, out_has_x3}), 64'(h.has));
        chk("m_out_ts",     64'(out_ts), TsEn ? 64'(h.ts) : 64'd0);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(input bit pv, input logic [2:0] h, input logic [DATA_W-1:0] a,
                       input logic [DATA_W-1:0] b, input logic [DATA_W-1:0] c,
                       input bit ordy, input bit clr);
    push_valid = pv;
    {has_x1, has_x2, has_x3} = h;
    x1 = a; x2 = b; x3 = c;
    out_ready = ordy;
    clr_overflow = clr;
  endtask

  task automatic idle(input bit ordy);
    drive(1'b0, 3'b000, '0, '0, '0, ordy, 1'b0);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_push_ready", 64'(push_ready), 64'd1);
    chk("rst_level", 64'(level), 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);
    rst = 1'b1;

    // Push at cycle 10 after reset release.
    repeat (10) @(negedge clk);
    drive(1'b1, 3'b110, 32'd1, 32'd2, 32'd0, 1'b0, 1'b0);
    @(negedge clk);
    idle(1'b0);
    chk("p1_valid", 64'(out_valid), 64'd1);
    chk("p1_x1", 64'(out_x1), 64'd1);
    chk("p1_x2", 64'(out_x2), 64'd2);
    chk("p1_has", 64'({out_has_x1, out_has_x2, out_has_x3}), 64'b110);
    chk("p1_ts", 64'(out_ts), TsEn ? 64'd10 : 64'd0);
    chk("p1_level", 64'(level), 64'd1);
    idle(1'b1);
    @(negedge clk);
    idle(1'b0);
    chk("p1_drained", 64'(out_valid), 64'd0);

    // Fill, overflow, drain.
    for (int i = 1; i <= 5; i++) begin
      drive(1'b1, 3'b001, 32'(i), '0, 32'(i * 3), 1'b0, 1'b0);
      @(negedge clk);
      if (i == 4) begin
        chk("fill_push_ready", 64'(push_ready), 64'd0);
        chk("fill_level", 64'(level), 64'd4);
      end
    end
    idle(1'b0);
    chk("ovf_set", 64'(overflow), 64'd1);
    chk("ovf_level", 64'(level), 64'd4);
    for (int i = 1; i <= 4; i++) begin
      chk("drain_x1", 64'(out_x1), 64'(i));
      idle(1'b1);
      @(negedge clk);
    end
    chk("drain_empty", 64'(out_valid), 64'd0);
    drive(1'b0, 3'b000, '0, '0, '0, 1'b0, 1'b1);
    @(negedge clk);
    idle(1'b0);
    chk("ovf_clr", 64'(overflow), 64'd0);

    // Two queued, simultaneous push/pop across pointer wrap.
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 3'b010, 32'(200 + i), 32'(i), '0, 1'b0, 1'b0);
      @(negedge clk);
    end
    for (int j = 0; j < 10; j++) begin
      chk("pp_level", 64'(level), 64'd2);
      chk("pp_x1", 64'(out_x1), 64'(200 + j));
      drive(1'b1, 3'b010, 32'(202 + j), 32'(j), '0, 1'b1, 1'b0);
      @(negedge clk);
    end
    chk("pp_level_end", 64'(level), 64'd2);
    chk("pp_x1_end", 64'(out_x1), 64'd210);
    idle(1'b1);
    repeat (2) @(negedge clk);
    idle(1'b0);

    // Push with no stream present.
    drive(1'b1, 3'b000, 32'd7, '0, '0, 1'b0, 1'b0);
    @(negedge clk);
    idle(1'b0);
    chk("nohas_level", 64'(level), 64'd0);
    chk("nohas_valid", 64'(out_valid), 64'd0);
    chk("nohas_ovf", 64'(overflow), 64'd0);

    // Full queue with simultaneous push and pop.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 3'b100, 32'(11 + i), '0, '0, 1'b0, 1'b0);
      @(negedge clk);
    end
    chk("full2_ready", 64'(push_ready), 64'd0);
    drive(1'b1, 3'b111, 32'd15, '0, '0, 1'b1, 1'b0);
    @(negedge clk);
    idle(1'b0);
    chk("fpp_level", 64'(level), 64'd3);
    chk("fpp_ovf", 64'(overflow), 64'd1);
    chk("fpp_head", 64'(out_x1), 64'd12);
    drive(1'b0, 3'b000, '0, '0, '0, 1'b0, 1'b1);
    @(negedge clk);
    idle(1'b0);
    chk("fpp_clr", 64'(overflow), 64'd0);

    // Reset mid-drain with 3 entries queued.
    idle(1'b1);
    #2 rst = 1'b0;
    #1;
    chk("mrst_valid", 64'(out_valid), 64'd0);
    chk("mrst_ready", 64'(push_ready), 64'd1);
    chk("mrst_level", 64'(level), 64'd0);
    chk("mrst_x1", 64'(out_x1), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    drive(1'b1, 3'b100, 32'd42, '0, '0, 1'b0, 1'b0);
    @(negedge clk);
    idle(1'b0);
    chk("mrst_push_x1", 64'(out_x1), 64'd42);
    chk("mrst_push_ts", 64'(out_ts), 64'd0);

    // Randomized phase with varying consumer pressure.
    for (int p = 0; p < 3; p++) begin
      for (int k = 0; k < 800; k++) begin
        drive($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), $urandom, $urandom,
              $urandom, $urandom_range(0, 3) <= p, $urandom_range(0, 15) == 0);
        @(negedge clk);
      end
    end
    idle(1'b0);
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
